// File: rtl/switch_debounce_reg.sv
// Switch input register: 2-flop synchroniser, per-channel debounce counters,
// sticky change flags with interrupt. Build with SWITCHES_IRQ_EN for flags/irq.
module switch_debounce_reg #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [WIDTH-1:0]  sw_i,
  input  logic              we_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       data_o,
  output logic [31:0]       change_o,
  output logic              irq_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] upd;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_i;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic             st;
    logic [CNT_W-1:0] cnt;

    // Counter only advances while the input disagrees with the accepted value,
    // and is cleared on acceptance, so it never exceeds CNT_MAX.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        st  <= 1'b0;
        cnt <= '0;
      end else if (sync2[i] == st) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        st  <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign stable[i] = st;
    assign upd[i]    = (sync2[i] != st) && (cnt == CNT_MAX);
  end

  always_comb begin
    data_o            = '0;
    data_o[WIDTH-1:0] = stable;
  end

`ifdef SWITCHES_IRQ_EN
  logic [WIDTH-1:0] chg;
  logic [WIDTH-1:0] clr;
  logic             unused_wdata;

  assign clr          = we_i ? wdata_i[WIDTH-1:0] : '0;
  assign unused_wdata = ^wdata_i;

  // Set has priority: a flag being cleared on the edge it is raised stays set.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      chg <= '0;
    end else begin
      chg <= (chg & ~clr) | upd;
    end
  end

  always_comb begin
    change_o            = '0;
    change_o[WIDTH-1:0] = chg;
  end

  assign irq_o = |chg;
`else
  logic unused_in;

  assign unused_in = ^{we_i, wdata_i, upd};
  assign change_o  = '0;
  assign irq_o     = 1'b0;
`endif

endmodule

// File: doc/switch_debounce_reg.md
# switch_debounce_reg

Parametrised successor to the switch input register. It samples up to 32 slide/push switches through a two-flop synchroniser and debounces each channel independently with its own counter. It presents the stable value zero-extended to 32 bits on the peripheral read bus and latches per-channel change flags that raise an interrupt to the RISC-V core. It sits between the board switch pins and the peripheral address decoder.

## Interface
- `WIDTH`, default 16: number of switch channels, legal range 1..32.
- `DEBOUNCE_CYCLES`, default 10000: consecutive stable cycles required before accepting a change (1 ms at 10 MHz), legal range ≥1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: counter width, derived; never overridden.
- `clk_i`, in, 1: system clock, 10 MHz.
- `rst_n_i`, in, 1: reset, asynchronous and active-low.
- `sw_i`, in, WIDTH: raw asynchronous switch pins.
- `we_i`, in, 1: write strobe to the change-flag register, one cycle.
- `wdata_i`, in, 32: write-1-to-clear mask for change flags; bits at and above WIDTH are ignored.
- `data_o`, out, 32: debounced switch value in bits [WIDTH-1:0]; upper bits are always 0.
- `change_o`, out, 32: sticky change flags in bits [WIDTH-1:0]; upper bits are always 0.
- `irq_o`, out, 1: OR-reduction of the change flags.

## Operation
- Reset asserted: synchroniser flops, debounced value, all counters, change flags and `irq_o` go to 0 immediately, without waiting for a clock edge.
- Synchroniser:
  - `sync1 <= sw_i`, then `sync2 <= sync1`.
  - Only `sync2` feeds the debounce logic.
- Per-channel debouncer, channel i, with `stable[i]` driving `data_o[i]`:
  - `sync2[i] == stable[i]`: `cnt[i] <= 0`.
  - `sync2[i] != stable[i]` and `cnt[i] < DEBOUNCE_CYCLES-1`: `cnt[i] <= cnt[i]+1`.
  - `sync2[i] != stable[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i] <= sync2[i]`, `cnt[i] <= 0`, and a one-cycle `upd[i]` is produced.
  - A glitch shorter than `DEBOUNCE_CYCLES` mismatching cycles resets the counter; `stable` does not change.
  - The counter saturates by construction and never wraps.
- Change flags (`chg`):
  - `upd[i]` sets `chg[i]`.
  - `we_i && wdata_i[i]` clears `chg[i]`.
  - When set and clear occur in the same cycle, set wins.
  - `irq_o = |chg`, combinational from the register.
- After reset release, channels whose pins are held high debounce up from 0 and set their flags. Boot software clears these flags.

## Timing
- `data_o` latency: with `sw_i` changing before edge 1 and held, `data_o` updates on edge `DEBOUNCE_CYCLES+2`. Two edges are spent in the synchroniser and `DEBOUNCE_CYCLES` edges in the counter.
- `change_o[i]` is set on the same edge that `data_o[i]` updates. `irq_o` follows in the same cycle.
- Clear: `change_o` drops on the edge that samples `we_i=1`; `irq_o` drops in the same cycle when no other flag remains set.
- Channels are fully independent. Simultaneous updates on several channels set all of the corresponding flags on the same edge.
- Reset asserted mid-count: state is lost and counting restarts from 0 after release.

## Configuration
- Macro `SWITCHES_IRQ_EN`.
- Defined:
  - The change-flag register, write-1-to-clear logic and `irq_o` are built.
- Undefined:
  - `change_o` and `irq_o` are tied to 0.
  - `we_i` and `wdata_i` are ignored.
  - The debounce path and `data_o` are unchanged.

## Test plan
All scenarios use WIDTH=16 and DEBOUNCE_CYCLES=4.
- Reset: assert `rst_n_i`=0 mid-cycle with `sw_i`=16'hFFFF → `data_o`=0, `change_o`=0 and `irq_o`=0 asynchronously. After release, `data_o`=32'h0000_FFFF on edge 6 and `change_o`=32'h0000_FFFF.
- Step: `sw_i` goes 0→16'h0005 and is held → `data_o` is 0 through edge 5 and 32'h0000_0005 on edge 6. `change_o`=32'h5 and `irq_o`=1 on edge 6.
- Glitch: `sw_i[3]` pulses high for 3 cycles, then low → `data_o[3]` stays 0 and `change_o[3]` stays 0.
- Chatter then settle: `sw_i[0]` toggles every 2 cycles for 10 cycles, then holds 1 → `data_o[0]`=1 exactly 6 edges after the final toggle.
- Clear: `change_o`=32'h5, then `we_i`=1 with `wdata_i`=32'h1 → `change_o`=32'h4 and `irq_o` stays 1. A second write with `wdata_i`=32'h4 → `change_o`=0 and `irq_o`=0.
- Set/clear collision: a clear of bit 1 in the same cycle as `upd[1]` → `change_o[1]`=1. With `SWITCHES_IRQ_EN` undefined, repeat the Step scenario → `change_o`=0 and `irq_o`=0 throughout.
